// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//
// Contents:
//   InstAddrBus        width of instruction addresses
//   ZeroWord           all-zero 32-bit word
//   ChipEnable/Disable instruction memory chip enable levels
//   RstEnable          level of rst that means "reset asserted" (active low)
//   ResetVectorDefault default first fetch address after reset
//   fetch_state_t      fetch FSM state encodings
package fetch_seq_pkg;

   localparam int          InstAddrBus        = 32;
   localparam logic [31:0] ZeroWord           = 32'h0000_0000;
   localparam logic        ChipEnable         = 1'b1;
   localparam logic        ChipDisable        = 1'b0;
   localparam logic        RstEnable          = 1'b0;
   localparam logic [31:0] ResetVectorDefault = 32'h0000_0000;

   typedef enum logic [1:0] {
      FetchRst  = 2'b00,
      FetchReq  = 2'b01,
      FetchHold = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/fetch_seq_redirect.sv
// pc_redirect_reg: pending redirect storage for the fetch sequencer.
//
// Holds the pending redirect target, its valid bit, the flush-priority bit
// and the squash flag. The redirect_* and squash outputs are the effective
// values for the current cycle: they already include any set request
// arriving this cycle, so a redirect that coincides with an advance is used
// immediately instead of waiting one more fetch.
//
// Ports:
//   clk            core clock
//   rst            synchronous active-low reset
//   branch_set     latch branch_target (ignored while a flush is pending)
//   branch_target  branch destination
//   flush_set      latch flush_target with flush priority
//   flush_target   exception vector / EPC
//   squash_set     mark the in-flight fetch as squashed
//   consume        the sequencer advanced this cycle; clear everything
//   redirect_valid  a redirect target is available
//   redirect_target the target to use on the next advance
//   redirect_flush  the available redirect is a flush (forces advance)
//   squash          the fetch being completed must not be reported
module pc_redirect_reg
   import fetch_seq_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   branch_set,
   input  logic [InstAddrBus-1:0] branch_target,
   input  logic                   flush_set,
   input  logic [InstAddrBus-1:0] flush_target,
   input  logic                   squash_set,
   input  logic                   consume,
   output logic                   redirect_valid,
   output logic [InstAddrBus-1:0] redirect_target,
   output logic                   redirect_flush,
   output logic                   squash
);

   logic                   valid_q;
   logic [InstAddrBus-1:0] target_q;
   logic                   flush_q;
   logic                   squash_q;

   // Merge incoming set requests with the stored redirect. A new flush
   // always wins; a stored flush is never displaced by a later branch;
   // otherwise a new branch overwrites whatever branch was pending.
   always_comb begin
      redirect_valid  = valid_q;
      redirect_target = target_q;
      redirect_flush  = flush_q;
      if (flush_set) begin
         redirect_valid  = 1'b1;
         redirect_target = flush_target;
         redirect_flush  = 1'b1;
      end else if (!flush_q && branch_set) begin
         redirect_valid  = 1'b1;
         redirect_target = branch_target;
         redirect_flush  = 1'b0;
      end
      squash = squash_q | squash_set;
   end

   // Store the effective redirect until the sequencer advances. Consuming
   // clears everything, including any request that arrived in the same
   // cycle, because that request was already used by the advance.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         valid_q  <= 1'b0;
         target_q <= ZeroWord;
         flush_q  <= 1'b0;
         squash_q <= 1'b0;
      end else if (consume) begin
         valid_q  <= 1'b0;
         target_q <= ZeroWord;
         flush_q  <= 1'b0;
         squash_q <= 1'b0;
      end else begin
         valid_q  <= redirect_valid;
         target_q <= redirect_target;
         flush_q  <= redirect_flush;
         squash_q <= squash;
      end
   end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: fetch sequencer owning the PC and instruction memory enable.
//
// Runs a single-outstanding req/ack handshake to instruction memory, holds
// the PC while the pipeline stalls, applies delay-slot preserving branch
// redirects and exception flushes, and reports each accepted, non-squashed
// instruction to the IF/ID register.
//
// Optional build macro: FETCH_PERF_EN adds perf_fetch_cnt_o (fetch_valid_o
// pulses) and perf_wait_cnt_o (REQ cycles without ack), both wrapping.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   stall_i           pipeline stall, PC holds while high
//   branch_flag_i     taken branch pulse, target in branch_target_i
//   flush_i           exception/eret flush pulse, target in new_pc_i
//   inst_ack_i        instruction memory completes the request
//   pc_o              current fetch address
//   ce_o              instruction memory chip enable
//   inst_req_o        fetch request, held until acknowledged
//   fetch_valid_o     one-cycle pulse for an accepted instruction
//   fetch_pc_o        address of that instruction
module fetch_seq
   import fetch_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = ResetVectorDefault,
   parameter logic [31:0] PC_STEP      = 32'h4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   branch_flag_i,
   input  logic [InstAddrBus-1:0] branch_target_i,
   input  logic                   flush_i,
   input  logic [InstAddrBus-1:0] new_pc_i,
   input  logic                   inst_ack_i,
   output logic [InstAddrBus-1:0] pc_o,
   output logic                   ce_o,
   output logic                   inst_req_o,
   output logic                   fetch_valid_o,
   output logic [InstAddrBus-1:0] fetch_pc_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]            perf_fetch_cnt_o,
   output logic [31:0]            perf_wait_cnt_o
`endif
);

   fetch_state_t           state;
   fetch_state_t           state_next;
   logic                   in_req;
   logic                   in_hold;
   logic                   active;
   logic                   advance;
   logic [InstAddrBus-1:0] pc_next;
   logic                   redirect_valid;
   logic [InstAddrBus-1:0] redirect_target;
   logic                   redirect_flush;
   logic                   squash;

   assign in_req  = (state == FetchReq);
   assign in_hold = (state == FetchHold);
   assign active  = (state != FetchRst);

   // Branches and flushes are only accepted once out of reset; a flush in
   // the same cycle as a branch discards the branch. Only a flush that
   // catches a fetch still in REQ squashes that fetch.
   pc_redirect_reg u_redirect (
      .clk             (clk),
      .rst             (rst),
      .branch_set      (branch_flag_i & active & ~flush_i),
      .branch_target   (branch_target_i),
      .flush_set       (flush_i & active),
      .flush_target    (new_pc_i),
      .squash_set      (flush_i & in_req),
      .consume         (advance),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .redirect_flush  (redirect_flush),
      .squash          (squash)
   );

   // Next-state, advance decision and memory interface outputs. A flush
   // redirect overrides stall so the exception vector is fetched at once;
   // an ack is only meaningful while a request is outstanding.
   always_comb begin
      state_next = state;
      advance    = 1'b0;
      ce_o       = ChipEnable;
      inst_req_o = 1'b0;
      pc_next    = redirect_valid ? redirect_target : pc_o + PC_STEP;
      case (state)
         FetchRst: begin
            ce_o       = ChipDisable;
            state_next = FetchReq;
         end
         FetchReq: begin
            inst_req_o = 1'b1;
            if (inst_ack_i) begin
               if (!stall_i || redirect_flush) begin
                  advance = 1'b1;
               end else begin
                  state_next = FetchHold;
               end
            end
         end
         FetchHold: begin
            if (!stall_i || redirect_flush) begin
               advance    = 1'b1;
               state_next = FetchReq;
            end
         end
         default: begin
            state_next = FetchRst;
         end
      endcase
   end

   // State register; reset always returns to RST so an outstanding request
   // is abandoned and later acks are ignored until REQ is re-entered.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state <= FetchRst;
      end else begin
         state <= state_next;
      end
   end

   // PC and accepted-instruction report. The report describes the address
   // that was just left behind, unless a flush squashed that fetch.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         pc_o          <= RESET_VECTOR;
         fetch_valid_o <= 1'b0;
         fetch_pc_o    <= ZeroWord;
      end else begin
         fetch_valid_o <= advance & ~squash;
         if (advance) begin
            pc_o       <= pc_next;
            fetch_pc_o <= pc_o;
         end
      end
   end

`ifdef FETCH_PERF_EN
   // Performance counters: accepted instructions and memory wait cycles.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         perf_fetch_cnt_o <= 32'h0;
         perf_wait_cnt_o  <= 32'h0;
      end else begin
         if (fetch_valid_o) begin
            perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'h1;
         end
         if (in_req && !inst_ack_i) begin
            perf_wait_cnt_o <= perf_wait_cnt_o + 32'h1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Testbench for fetch_seq: a cycle-by-cycle vector table followed by a few
// hand-written flush sequences. Each table row holds the outputs expected
// at the start of a cycle and the inputs driven during that cycle.
module tb_fetch_seq;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        br;
      logic [31:0] btgt;
      logic        fl;
      logic [31:0] npc;
      logic        ack;
      logic [31:0] pc;
      logic        ce;
      logic        req;
      logic        fv;
      logic [31:0] fpc;
   } vec_t;

   localparam int NumVecs = 32;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        inst_ack_i;
   logic [31:0] pc_o;
   logic        ce_o;
   logic        inst_req_o;
   logic        fetch_valid_o;
   logic [31:0] fetch_pc_o;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt_o;
   logic [31:0] perf_wait_cnt_o;
`endif

   int   checks;
   int   errors;
   vec_t vecs[NumVecs];

   fetch_seq dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .flush_i         (flush_i),
      .new_pc_i        (new_pc_i),
      .inst_ack_i      (inst_ack_i),
      .pc_o            (pc_o),
      .ce_o            (ce_o),
      .inst_req_o      (inst_req_o),
      .fetch_valid_o   (fetch_valid_o),
      .fetch_pc_o      (fetch_pc_o)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt_o(perf_fetch_cnt_o),
      .perf_wait_cnt_o (perf_wait_cnt_o)
`endif
   );

   // Free-running core clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mkVec(
      input logic rs, input logic st, input logic b, input logic [31:0] bt,
      input logic f, input logic [31:0] np, input logic a,
      input logic [31:0] p, input logic c, input logic r, input logic v,
      input logic [31:0] fp);
      vec_t t;
      t.rst = rs; t.stall = st; t.br = b; t.btgt = bt;
      t.fl = f; t.npc = np; t.ack = a;
      t.pc = p; t.ce = c; t.req = r; t.fv = v; t.fpc = fp;
      return t;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst             = v.rst;
      stall_i         = v.stall;
      branch_flag_i   = v.br;
      branch_target_i = v.btgt;
      flush_i         = v.fl;
      new_pc_i        = v.npc;
      inst_ack_i      = v.ack;
   endtask

   // fetch_pc_o is only meaningful alongside fetch_valid_o or in reset.
   task automatic checkOutput(input int idx, input vec_t v);
      checkValue($sformatf("pc_o[%0d]", idx), pc_o, v.pc);
      checkValue($sformatf("ce_o[%0d]", idx), {31'h0, ce_o}, {31'h0, v.ce});
      checkValue($sformatf("inst_req_o[%0d]", idx), {31'h0, inst_req_o}, {31'h0, v.req});
      checkValue($sformatf("fetch_valid_o[%0d]", idx), {31'h0, fetch_valid_o}, {31'h0, v.fv});
      if (v.fv || !v.ce) begin
         checkValue($sformatf("fetch_pc_o[%0d]", idx), fetch_pc_o, v.fpc);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //                 rst st br btgt         fl npc           ack  pc            ce req fv fpc
      vecs[0]  = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        0,   32'h0,        0, 0, 0, 32'h0);
      vecs[1]  = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h0,        1, 1, 0, 32'h0);
      vecs[2]  = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h4,        1, 1, 1, 32'h0);
      vecs[3]  = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        0,   32'h8,        1, 1, 1, 32'h4);
      vecs[4]  = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        0,   32'h8,        1, 1, 0, 32'h4);
      vecs[5]  = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        0,   32'h8,        1, 1, 0, 32'h4);
      vecs[6]  = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h8,        1, 1, 0, 32'h4);
      vecs[7]  = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'hC,        1, 1, 1, 32'h8);
      vecs[8]  = mkVec(1, 0, 1, 32'h100,     0, 32'h0,        0,   32'h10,       1, 1, 1, 32'hC);
      vecs[9]  = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h10,       1, 1, 0, 32'hC);
      vecs[10] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h100,      1, 1, 1, 32'h10);
      vecs[11] = mkVec(1, 0, 1, 32'h20,      0, 32'h0,        0,   32'h104,      1, 1, 1, 32'h100);
      vecs[12] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h104,      1, 1, 0, 32'h100);
      vecs[13] = mkVec(1, 0, 0, 32'h0,       1, 32'h80000180, 0,   32'h20,       1, 1, 1, 32'h104);
      vecs[14] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        0,   32'h20,       1, 1, 0, 32'h104);
      vecs[15] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h20,       1, 1, 0, 32'h104);
      vecs[16] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h80000180, 1, 1, 0, 32'h20);
      vecs[17] = mkVec(1, 0, 1, 32'h30,      0, 32'h0,        0,   32'h80000184, 1, 1, 1, 32'h80000180);
      vecs[18] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h80000184, 1, 1, 0, 32'h80000180);
      vecs[19] = mkVec(1, 1, 0, 32'h0,       0, 32'h0,        1,   32'h30,       1, 1, 1, 32'h80000184);
      vecs[20] = mkVec(1, 1, 0, 32'h0,       0, 32'h0,        0,   32'h30,       1, 0, 0, 32'h80000184);
      vecs[21] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        0,   32'h30,       1, 0, 0, 32'h80000184);
      vecs[22] = mkVec(1, 0, 1, 32'h200,     1, 32'h400,      0,   32'h34,       1, 1, 1, 32'h30);
      vecs[23] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h34,       1, 1, 0, 32'h30);
      vecs[24] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h400,      1, 1, 0, 32'h34);
      vecs[25] = mkVec(0, 0, 0, 32'h0,       0, 32'h0,        0,   32'h404,      1, 1, 1, 32'h400);
      vecs[26] = mkVec(0, 0, 0, 32'h0,       0, 32'h0,        1,   32'h0,        0, 0, 0, 32'h0);
      vecs[27] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        0,   32'h0,        0, 0, 0, 32'h0);
      vecs[28] = mkVec(1, 0, 0, 32'h0,       0, 32'h0,        1,   32'h0,        1, 1, 0, 32'h0);
      vecs[29] = mkVec(1, 1, 0, 32'h0,       0, 32'h0,        1,   32'h4,        1, 1, 1, 32'h0);
      vecs[30] = mkVec(1, 1, 0, 32'h0,       0, 32'h0,        1,   32'h4,        1, 0, 0, 32'h0);
      vecs[31] = mkVec(1, 1, 0, 32'h0,       0, 32'h0,        0,   32'h4,        1, 0, 0, 32'h0);

      // Hold reset for two edges before the table starts.
      applyStimulus(mkVec(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0));
      @(negedge clk);
      @(negedge clk);

      for (int i = 0; i < NumVecs; i++) begin
         @(negedge clk);
         checkOutput(i, vecs[i]);
`ifdef FETCH_PERF_EN
         if (i == 6) begin
            checkValue("perf_wait_cnt_o", perf_wait_cnt_o, 32'd3);
         end
`endif
         applyStimulus(vecs[i]);
      end

      // Flush while in HOLD with stall still high: advance happens at once.
      @(negedge clk);
      checkValue("hold_before_flush_req", {31'h0, inst_req_o}, 32'h0);
      applyStimulus(mkVec(1, 1, 0, 32'h0, 1, 32'h1000, 0, 32'h0, 0, 0, 0, 32'h0));
      @(negedge clk);
      checkValue("hold_flush_pc", pc_o, 32'h1000);
      checkValue("hold_flush_req", {31'h0, inst_req_o}, 32'h1);

      // Flush coinciding with ack: redirect taken now, fetch squashed.
      applyStimulus(mkVec(1, 0, 0, 32'h0, 1, 32'h2000, 1, 32'h0, 0, 0, 0, 32'h0));
      @(negedge clk);
      checkValue("ack_flush_pc", pc_o, 32'h2000);
      checkValue("ack_flush_valid", {31'h0, fetch_valid_o}, 32'h0);

      // Plain sequential fetch resumes from the flush target.
      applyStimulus(mkVec(1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0));
      @(negedge clk);
      checkValue("after_flush_pc", pc_o, 32'h2004);
      checkValue("after_flush_valid", {31'h0, fetch_valid_o}, 32'h1);
      checkValue("after_flush_fetch_pc", fetch_pc_o, 32'h2000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
